gray_step_ctrl: RTL and testbench
=================================

// Module: gray_step_ctrl
//
// PURPOSE
// Step scheduler for the Gray counter datapath. It decides when the counter advances and in which direction.
// Sources: an internal prescaled tick (auto mode) or a debounced manual clock button (manual mode).
// Sits between the board inputs (button/switches) and the counter enable/direction inputs of top.
// Output is a single-cycle o_step strobe in the i_clk domain. The counter is never clocked by the button.
//
// PARAMETERS
// CLK_FREQ_HZ      100_000_000  i_clk frequency
// STEP_FREQ_HZ     1            auto-mode step rate; DIV = CLK_FREQ_HZ/STEP_FREQ_HZ (integer, >=1)
// DEBOUNCE_CYCLES  1_000_000    cycles synced button must be stable before accepted (>=1)
//
// PORTS
// i_clk         in   1  system clock
// i_rst         in   1  asynchronous reset, active-high
// i_man_clk     in   1  manual clock push-button, asynchronous, bouncy
// i_man_clk_en  in   1  mode switch, asynchronous: 0 = auto, 1 = manual
// i_dir         in   1  direction switch, asynchronous: 0 = up, 1 = down
// o_step        out  1  one-cycle counter enable strobe
// o_dir         out  1  direction to apply with o_step
// o_mode        out  1  active mode: 0 = auto, 1 = manual (changes only on FSM exit from S_SWITCH)
//
// BEHAVIOUR
// - Reset (async, immediate): o_step=0, o_dir=0, o_mode=0, FSM=S_AUTO, prescaler=0, debounce cnt=0, debounced btn=0, sync flops=0.
// - All three async inputs pass through 2-flop synchronizers; the sync value is valid 2 cycles after the pin change.
// - Debounce: counter restarts on every synced-button change. The debounced level updates when the synced level has held for DEBOUNCE_CYCLES cycles.
// - Manual request = rising edge of the debounced level. A release never produces a step.
// - Prescaler: width $clog2(DIV) (min 1); counts 0..DIV-1 and wraps. Auto request when count==DIV-1.
//   DIV==1: request every cycle.
// - FSM states (synced mode bit = m):
//   S_AUTO:   o_step=1 next cycle on auto request; if m==1 -> S_SWITCH
//   S_MANUAL: o_step=1 next cycle on manual request; if m==0 -> S_SWITCH
//   S_SWITCH: no steps; prescaler held at 0; exits when debounced btn==0
//             -> S_MANUAL if m==1 else S_AUTO; o_mode updated on exit
//   If m flips back while in S_SWITCH, the target follows the current m.
// - Requests from the inactive source are ignored and never queued.
// - Mode change in the same cycle as a request: the mode change wins and no step is issued.
// - A button held through a switch into manual mode gives no step until released and pressed again.
// - o_dir loads the synced dir only in cycles where o_step is not being asserted next cycle.
//   o_dir is stable for the whole step pulse and never changes in the same cycle o_step=1.
// - Latency: auto step = 1 cycle after prescaler==DIV-1. Manual step = 2 sync + DEBOUNCE_CYCLES + 1 cycles after a clean press.
//   Dir change reaches o_dir 3 cycles after the pin unless deferred by a step.
// - o_step is never high for 2 consecutive cycles, except when DIV==1 in auto mode.
// - Reset mid-operation aborts any step/debounce and restarts in S_AUTO with prescaler 0.
//
// TESTING (overrides: CLK_FREQ_HZ=10, STEP_FREQ_HZ=1 -> DIV=10, DEBOUNCE_CYCLES=3; 10 ns clock)
// 1 Reset: assert i_rst mid-prescale -> all outputs 0 same cycle; after release, first o_step 10 cycles later, 1 cycle wide.
// 2 Auto: en=0, dir=0, 100 cycles -> exactly 10 o_step pulses spaced 10 cycles; o_mode=0; button activity ignored.
// 3 Manual bounce: en=1, toggle i_man_clk every cycle for 20 cycles -> no o_step.
//   Then hold high 10 cycles -> exactly one o_step, 6 cycles after the edge. Release -> none.
// 4 Switch with button held: button high, en 0->1 -> o_mode stays 0 and no step until release.
//   After release o_mode=1; a new press gives one step.
// 5 Direction: toggle i_dir -> o_dir follows 3 cycles later; when a toggle lands on a step cycle, o_dir changes the cycle after o_step.
// 6 Collision: flip en on the cycle prescaler==9 -> no o_step issued; FSM enters S_SWITCH.

Source files
------------

// File: rtl/gray_step_ctrl.sv
// Step scheduler for the Gray counter datapath.
// Turns either a prescaled internal tick (auto mode) or a debounced push-button (manual mode)
// into a single-cycle step strobe with an accompanying direction. All board inputs are
// synchronised. The button never clocks anything directly.
module gray_step_ctrl #(
   parameter int unsigned CLK_FREQ_HZ     = 100_000_000,
   parameter int unsigned STEP_FREQ_HZ    = 1,
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_man_clk,
   input  logic i_man_clk_en,
   input  logic i_dir,
   output logic o_step,
   output logic o_dir,
   output logic o_mode
);

   localparam int unsigned Div  = CLK_FREQ_HZ / STEP_FREQ_HZ;
   localparam int unsigned PreW = (Div > 1) ? $clog2(Div) : 1;
   localparam int unsigned DebW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [PreW-1:0] PreMax = PreW'(Div - 1);
   localparam logic [DebW-1:0] DebMax = DebW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      StAuto   = 2'd0,
      StManual = 2'd1,
      StSwitch = 2'd2
   } state_e;

   logic [1:0]      btn_sync_q, en_sync_q, dir_sync_q;
   logic            btn_s, en_s, dir_s;
   logic [DebW-1:0] deb_cnt_q, deb_cnt_d;
   logic            deb_btn_q, deb_btn_d;
   logic            deb_prev_q;
   logic [PreW-1:0] pre_q, pre_d;
   state_e          state_q, state_d;
   logic            step_q, step_d;
   logic            dir_q, dir_d;
   logic            mode_q, mode_d;
   logic            auto_req, man_req;

   assign btn_s = btn_sync_q[1];
   assign en_s  = en_sync_q[1];
   assign dir_s = dir_sync_q[1];

   // Two-flop synchronisers for the three asynchronous board inputs.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         btn_sync_q <= '0;
         en_sync_q  <= '0;
         dir_sync_q <= '0;
      end else begin
         btn_sync_q <= {btn_sync_q[0], i_man_clk};
         en_sync_q  <= {en_sync_q[0], i_man_clk_en};
         dir_sync_q <= {dir_sync_q[0], i_dir};
      end
   end

   // Debounce: count while the synced level differs from the accepted one; any return resets.
   always_comb begin
      deb_cnt_d = '0;
      deb_btn_d = deb_btn_q;
      if (btn_s != deb_btn_q) begin
         if (deb_cnt_q == DebMax) begin
            deb_btn_d = btn_s;
         end else begin
            deb_cnt_d = deb_cnt_q + DebW'(1);
         end
      end
   end

   // Manual request is the rising edge of the accepted button level; release is ignored.
   assign man_req  = deb_btn_q & ~deb_prev_q;
   assign auto_req = (pre_q == PreMax);

   // Scheduler FSM next-state, step, mode, prescaler and direction logic.
   always_comb begin
      state_d = state_q;
      step_d  = 1'b0;
      mode_d  = mode_q;
      pre_d   = (pre_q == PreMax) ? '0 : pre_q + PreW'(1);
      unique case (state_q)
         StAuto: begin
            // A mode change in the same cycle as a request wins; the request is dropped.
            if (en_s) state_d = StSwitch;
            else if (auto_req) step_d = 1'b1;
         end
         StManual: begin
            if (!en_s) state_d = StSwitch;
            else if (man_req) step_d = 1'b1;
         end
         StSwitch: begin
            // Wait for the button to be released so a held press cannot step the new mode.
            pre_d = '0;
            if (!deb_btn_q) begin
               state_d = en_s ? StManual : StAuto;
               mode_d  = en_s;
            end
         end
         default: state_d = StAuto;
      endcase
      // Hold direction while a step is about to be issued so it is stable across the pulse.
      dir_d = step_d ? dir_q : dir_s;
   end

   // State registers.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         deb_cnt_q  <= '0;
         deb_btn_q  <= 1'b0;
         deb_prev_q <= 1'b0;
         pre_q      <= '0;
         state_q    <= StAuto;
         step_q     <= 1'b0;
         dir_q      <= 1'b0;
         mode_q     <= 1'b0;
      end else begin
         deb_cnt_q  <= deb_cnt_d;
         deb_btn_q  <= deb_btn_d;
         deb_prev_q <= deb_btn_q;
         pre_q      <= pre_d;
         state_q    <= state_d;
         step_q     <= step_d;
         dir_q      <= dir_d;
         mode_q     <= mode_d;
      end
   end

   assign o_step = step_q;
   assign o_dir  = dir_q;
   assign o_mode = mode_q;

endmodule

// File: tb/tb_gray_step_ctrl.sv
// Scoreboard bench for gray_step_ctrl with DIV=10 and DEBOUNCE_CYCLES=3.
// Stimulus pushes the expected cycle/dir/mode of every step; the monitor pops on each o_step.
module tb_gray_step_ctrl;

   logic clk = 1'b0;
   logic rst, btn, en, dir;
   logic o_step, o_dir, o_mode;

   typedef struct {
      int   cyc;
      logic dir;
      logic mode;
   } exp_t;

   exp_t exp_q[$];
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   gray_step_ctrl #(
      .CLK_FREQ_HZ    (10),
      .STEP_FREQ_HZ   (1),
      .DEBOUNCE_CYCLES(3)
   ) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_man_clk   (btn),
      .i_man_clk_en(en),
      .i_dir       (dir),
      .o_step      (o_step),
      .o_dir       (o_dir),
      .o_mode      (o_mode)
   );

   // Count rising edges; at a falling edge cyc equals the number of edges seen so far.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic push_step(input int c, input logic d, input logic m);
      exp_t e;
      e.cyc  = c;
      e.dir  = d;
      e.mode = m;
      exp_q.push_back(e);
   endtask

   task automatic wait_cyc(input int n);
      while (cyc < n) @(negedge clk);
   endtask

   task automatic chk(input string name, input logic act, input logic want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s at cyc %0d: got %0b expected %0b", name, cyc, act, want);
      end
   endtask

   // Monitor: compare every presented step against the queue head; flag missed steps.
   always @(negedge clk) begin
      exp_t e;
      if (o_step === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_step at cyc %0d dir %0b mode %0b", cyc, o_dir, o_mode);
         end else begin
            e = exp_q.pop_front();
            if (e.cyc != cyc || e.dir !== o_dir || e.mode !== o_mode) begin
               errors++;
               $display("FAIL step: got cyc %0d dir %0b mode %0b expected cyc %0d dir %0b mode %0b",
                        cyc, o_dir, o_mode, e.cyc, e.dir, e.mode);
            end
         end
      end
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
         e = exp_q.pop_front();
         checks++;
         errors++;
         $display("FAIL missed_step: got none expected step at cyc %0d", e.cyc);
      end
   end

   initial begin
      int r, m, p, a, d, p5;
      rst = 1'b1;
      btn = 1'b0;
      en  = 1'b0;
      dir = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_step", o_step, 1'b0);
      chk("reset_dir", o_dir, 1'b0);
      chk("reset_mode", o_mode, 1'b0);

      // First step 10 cycles after release; reset asserted during it clears outputs at once.
      rst = 1'b0;
      r   = cyc;
      push_step(r + 10, 1'b0, 1'b0);
      wait_cyc(r + 10);
      #2 rst = 1'b1;
      #1;
      chk("async_reset_step", o_step, 1'b0);
      chk("async_reset_dir", o_dir, 1'b0);
      chk("async_reset_mode", o_mode, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      r   = cyc;

      // Auto mode: ten steps in 100 cycles, button activity ignored.
      for (int k = 1; k <= 10; k++) push_step(r + 10 * k, 1'b0, 1'b0);
      wait_cyc(r + 30);
      btn = 1'b1;
      wait_cyc(r + 50);
      btn = 1'b0;
      wait_cyc(r + 100);
      chk("auto_mode", o_mode, 1'b0);

      // Collision: synced mode bit rises in the prescaler==9 cycle, so no step at r+110.
      wait_cyc(r + 107);
      en = 1'b1;
      wait_cyc(r + 110);
      chk("collision_mode_held", o_mode, 1'b0);
      wait_cyc(r + 112);
      chk("collision_mode_manual", o_mode, 1'b1);

      // Manual bounce: 20 single-cycle toggles give nothing; a clean press steps 6 cycles later.
      m = r + 120;
      for (int i = 0; i < 20; i++) begin
         wait_cyc(m + i);
         btn = ~btn;
      end
      p = m + 25;
      wait_cyc(p);
      btn = 1'b1;
      push_step(p + 6, 1'b0, 1'b1);
      wait_cyc(p + 10);
      btn = 1'b0;

      // Back to auto, then switch to manual while the button is held.
      a = p + 20;
      wait_cyc(a);
      en = 1'b0;
      push_step(a + 14, 1'b0, 1'b0);
      push_step(a + 24, 1'b0, 1'b0);
      wait_cyc(a + 15);
      btn = 1'b1;
      wait_cyc(a + 25);
      en = 1'b1;
      wait_cyc(a + 40);
      chk("held_switch_mode", o_mode, 1'b0);
      wait_cyc(a + 45);
      btn = 1'b0;
      wait_cyc(a + 50);
      chk("held_switch_mode_late", o_mode, 1'b0);
      wait_cyc(a + 52);
      chk("released_switch_mode", o_mode, 1'b1);
      wait_cyc(a + 60);
      btn = 1'b1;
      push_step(a + 66, 1'b0, 1'b1);
      wait_cyc(a + 70);
      btn = 1'b0;

      // Direction: plain follow in 3 cycles, then a change deferred past a step.
      d = a + 80;
      wait_cyc(d);
      dir = 1'b1;
      wait_cyc(d + 2);
      chk("dir_before", o_dir, 1'b0);
      wait_cyc(d + 3);
      chk("dir_follow", o_dir, 1'b1);
      p5 = d + 10;
      wait_cyc(p5);
      btn = 1'b1;
      push_step(p5 + 6, 1'b1, 1'b1);
      wait_cyc(p5 + 3);
      dir = 1'b0;
      wait_cyc(p5 + 6);
      chk("dir_held_on_step", o_dir, 1'b1);
      wait_cyc(p5 + 7);
      chk("dir_after_step", o_dir, 1'b0);
      wait_cyc(p5 + 10);
      btn = 1'b0;

      wait_cyc(p5 + 30);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL pending_steps: got %0d left expected 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
